// File: rtl/router_pkg.sv
// Shared definitions for the router synchroniser slice.
// Holds the default port count, address width, timeout counter width
// and the default timeout value used by router_sync_n and its timers.
package router_pkg;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_ADDR_W    = 2;
    localparam int DEF_TMO_W     = 5;
    localparam int DEF_TIMEOUT   = 30;

endpackage : router_pkg

// File: rtl/router_port_timer.sv
// Per-port stall timer.
// Counts consecutive cycles in which the port holds valid data that is
// not being read. When the count reaches the programmed timeout it
// emits a one-cycle soft-reset pulse and starts counting again.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   vld_i        port has data (FIFO not empty)
//   rd_i         port is being read this cycle
//   tmo_i        timeout in cycles; 0 disables the timer
//   soft_reset_o registered one-cycle timeout pulse
//   cnt_o        current stall count (observability)
module router_port_timer
    import router_pkg::*;
#(
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_i,
    input  logic             rd_i,
    input  logic [TMO_W-1:0] tmo_i,
    output logic             soft_reset_o,
    output logic [TMO_W-1:0] cnt_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             soft_reset_q, soft_reset_d;
    logic             stall;

    assign stall = vld_i && !rd_i && (tmo_i != '0);

    always_comb begin
        cnt_d        = '0;
        soft_reset_d = 1'b0;
        if (stall) begin
            // >= rather than == so a timeout lowered mid-count fires on the
            // next stall cycle instead of running the counter around.
            if (cnt_q >= tmo_i - TMO_W'(1)) begin
                cnt_d        = '0;
                soft_reset_d = 1'b1;
            end else begin
                cnt_d        = cnt_q + TMO_W'(1);
                soft_reset_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset_o = soft_reset_q;
    assign cnt_o        = cnt_q;

endmodule : router_port_timer

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the destination address, decodes it into
// a one-hot FIFO write enable, reflects the addressed FIFO's full flag
// back to the router FSM, and watches every output port for stalls.
//
// Handshake: vld_out[i] is high whenever FIFO i holds data; a word is
// consumed on a cycle where vld_out[i] and read_enb[i] are both high.
// A port that stays valid without being read for timeout_val cycles gets
// a one-cycle soft_reset[i] pulse.
//
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   data_in        destination address, captured when detect_add=1
//   detect_add     address capture strobe
//   write_enb_reg  write request for the addressed port
//   timeout_val    stall cycles before soft reset (0 disables timers)
//   read_enb       per-port read strobe
//   empty, full    per-port FIFO flags
//   vld_out        per-port valid (~empty)
//   write_enb      one-hot (or zero) FIFO write enable
//   fifo_full      full flag of the addressed port (1 on bad address)
//   addr_err       latched address is not a valid port
//   soft_reset     per-port one-cycle timeout pulse
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TMO_W     = DEF_TMO_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 detect_add,
    input  logic                 write_enb_reg,
    input  logic [TMO_W-1:0]     timeout_val,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic                 addr_err,
    output logic [NUM_PORTS-1:0] soft_reset
);

    logic [ADDR_W-1:0] int_addr_q, int_addr_d;

    assign int_addr_d = detect_add ? data_in : int_addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_addr_q <= '0;
        end else begin
            int_addr_q <= int_addr_d;
        end
    end

    // Decode uses the registered address, so a write in the same cycle as
    // a new address capture still goes to the previously latched port.
    assign addr_err = (int'(int_addr_q) >= NUM_PORTS);

    always_comb begin
        write_enb = '0;
        fifo_full = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!addr_err && (int_addr_q == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [TMO_W-1:0] cnt;

        router_port_timer #(
            .TMO_W (TMO_W)
        ) u_timer (
            .clock        (clock),
            .reset        (reset),
            .vld_i        (vld_out[g]),
            .rd_i         (read_enb[g]),
            .tmo_i        (timeout_val),
            .soft_reset_o (soft_reset[g]),
            .cnt_o        (cnt)
        );
    end

endmodule : router_sync_n

// File: tb/tb_router_sync_n.sv
module tb_router_sync_n;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TW = 5;

    logic          clock;
    logic          reset;
    logic [AW-1:0] data_in;
    logic          detect_add;
    logic          write_enb_reg;
    logic [TW-1:0] timeout_val;
    logic [NP-1:0] read_enb;
    logic [NP-1:0] empty;
    logic [NP-1:0] full;
    logic [NP-1:0] vld_out;
    logic [NP-1:0] write_enb;
    logic          fifo_full;
    logic          addr_err;
    logic [NP-1:0] soft_reset;

    int checks;
    int errors;

    router_sync_n #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .TMO_W     (TW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .timeout_val   (timeout_val),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .vld_out       (vld_out),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .addr_err      (addr_err),
        .soft_reset    (soft_reset)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one clock: wait for the edge, then settle away from it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks_expect(input string tag, input int n, input logic [NP-1:0] exp);
        for (int k = 0; k < n; k++) begin
            tick();
            check(tag, 32'(soft_reset), 32'(exp));
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        data_in       = '0;
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        timeout_val   = '0;
        read_enb      = '0;
        empty         = 3'b111;
        full          = 3'b000;

        // reset state, before any clock edge
        #2;
        check("rst_soft_reset", 32'(soft_reset), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        check("rst_write_enb", 32'(write_enb), 32'h0);
        check("rst_vld_out", 32'(vld_out), 32'h0);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
        full = 3'b001;
        #1;
        check("rst_fifo_full_p0", 32'(fifo_full), 32'h1);
        full = 3'b000;
        tick();
        tick();
        reset = 1'b0;

        // address 2, write in the capture cycle uses the old address 0
        data_in       = 2'd2;
        detect_add    = 1'b1;
        write_enb_reg = 1'b1;
        #1;
        check("same_cycle_wen", 32'(write_enb), 32'h1);
        tick();
        detect_add = 1'b0;
        #1;
        check("addr2_wen", 32'(write_enb), 32'h4);
        check("addr2_err", 32'(addr_err), 32'h0);
        full = 3'b100;
        #1;
        check("addr2_full_hi", 32'(fifo_full), 32'h1);
        full = 3'b011;
        #1;
        check("addr2_full_lo", 32'(fifo_full), 32'h0);

        // bad address 3
        data_in    = 2'd3;
        detect_add = 1'b1;
        tick();
        detect_add = 1'b0;
        full       = 3'b000;
        #1;
        check("addr3_wen", 32'(write_enb), 32'h0);
        check("addr3_err", 32'(addr_err), 32'h1);
        check("addr3_full", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b0;

        // vld_out follows ~empty
        empty = 3'b101;
        #1;
        check("vld_010", 32'(vld_out), 32'h2);
        empty = 3'b000;
        #1;
        check("vld_111", 32'(vld_out), 32'h7);
        empty = 3'b111;
        tick();

        // timeout 30 on port 0 for 65 stall cycles
        timeout_val = 5'd30;
        empty       = 3'b110;
        read_enb    = '0;
        for (int k = 1; k <= 65; k++) begin
            tick();
            check("tmo30_p0", 32'(soft_reset), ((k == 30) || (k == 60)) ? 32'h1 : 32'h0);
        end
        empty = 3'b111;
        tick();

        // timeout 5 on port 1, interrupted by one read
        timeout_val = 5'd5;
        empty       = 3'b101;
        ticks_expect("tmo5_pre_read", 3, 3'b000);
        read_enb = 3'b010;
        ticks_expect("tmo5_read", 1, 3'b000);
        read_enb = 3'b000;
        ticks_expect("tmo5_post_read", 4, 3'b000);
        ticks_expect("tmo5_fire", 1, 3'b010);
        ticks_expect("tmo5_one_cycle", 1, 3'b000);

        // lowering the timeout mid-count fires on the next stall cycle
        empty = 3'b111;
        tick();
        timeout_val = 5'd30;
        empty       = 3'b101;
        ticks_expect("lower_pre", 10, 3'b000);
        timeout_val = 5'd5;
        ticks_expect("lower_fire", 1, 3'b010);

        // async reset while a pulse is high; address register also clears
        empty = 3'b111;
        tick();
        empty = 3'b011;
        ticks_expect("arst_pre", 4, 3'b000);
        ticks_expect("arst_pulse", 1, 3'b100);
        check("arst_addr_err_before", 32'(addr_err), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_soft_reset", 32'(soft_reset), 32'h0);
        check("arst_addr_err", 32'(addr_err), 32'h0);
        write_enb_reg = 1'b1;
        #1;
        check("arst_wen_p0", 32'(write_enb), 32'h1);
        write_enb_reg = 1'b0;
        tick();
        reset = 1'b0;

        // reset mid-count discards progress on port 2
        timeout_val = 5'd30;
        ticks_expect("midrst_pre", 10, 3'b000);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_soft_reset", 32'(soft_reset), 32'h0);
        tick();
        reset = 1'b0;
        ticks_expect("midrst_restart", 29, 3'b000);
        ticks_expect("midrst_fire", 1, 3'b100);

        // timers disabled
        empty = 3'b111;
        tick();
        timeout_val = 5'd0;
        empty       = 3'b000;
        read_enb    = 3'b000;
        ticks_expect("tmo0_all", 100, 3'b000);

        // independent timers firing together
        timeout_val = 5'd3;
        ticks_expect("simul_pre", 2, 3'b000);
        ticks_expect("simul_fire", 1, 3'b111);
        ticks_expect("simul_after", 1, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_router_sync_n
